// File: rtl/golden_nonce_tx_queue_if.sv
// golden_nonce_tx_queue_if
//  Groups the push side (from the hasher control unit) and the byte-transmit side (to async_tx)
//  of the golden nonce queue.
//  Signals:
//   push        1   one-cycle strobe, golden nonce valid this cycle
//   push_nonce  32  golden nonce, sampled when push=1
//   tx_busy     1   async_tx busy flag
//   tx_start    1   one-cycle strobe to async_tx
//   tx_data     8   byte to transmit, valid while tx_start=1
//  Modports:
//   master  environment side (control unit + async_tx): drives push/push_nonce/tx_busy
//   slave   queue side: drives tx_start/tx_data
interface golden_nonce_tx_queue_if;
    logic        push;
    logic [31:0] push_nonce;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;

    modport master (
        output push,
        output push_nonce,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );

    modport slave (
        input  push,
        input  push_nonce,
        input  tx_busy,
        output tx_start,
        output tx_data
    );
endinterface

// File: rtl/golden_nonce_tx_queue.sv
// golden_nonce_tx_queue
//  Buffers golden nonces from the hasher control unit in a small circular FIFO and serialises
//  each one into four bytes for the async_tx UART transmitter. Overflowing pushes are dropped
//  and counted (saturating at 255).
//  Parameters:
//   DEPTH_LOG2  log2 of FIFO depth (must be >= 1)
//   MSB_FIRST   0: send nonce byte [7:0] first; 1: send byte [31:24] first
//  Ports:
//   clk         hash_clk, all logic on posedge
//   reset_in    asynchronous active-low reset
//   bus         slave side of golden_nonce_tx_queue_if (push/push_nonce/tx_busy in,
//               tx_start/tx_data out)
//   empty       FIFO holds no nonce
//   full        FIFO holds DEPTH nonces
//   level       FIFO occupancy, 0..DEPTH
//   drop_count  nonces discarded on overflow, saturating
//   sending     transmit FSM not idle
module golden_nonce_tx_queue #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset_in,
    golden_nonce_tx_queue_if.slave        bus,
    output logic                          empty,
    output logic                          full,
    output logic [DEPTH_LOG2:0]           level,
    output logic [7:0]                    drop_count,
    output logic                          sending
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StAck,
        StWait
    } state_e;

    state_e                state_q;
    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q;
    logic [DEPTH_LOG2:0]   rd_ptr_q;
    logic [7:0]            drop_count_q;
    logic [31:0]           sh_q;
    logic [1:0]            byte_cnt_q;
    logic                  tx_start_q;
    logic [7:0]            tx_data_q;
    logic                  sending_q;

    logic                  pop;
    logic                  push_ok;
    logic                  drop;
    logic [31:0]           head;

    function automatic logic [7:0] first_byte(input logic [31:0] w);
        return MSB_FIRST ? w[31:24] : w[7:0];
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    assign head    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign pop     = (state_q == StLoad);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok = bus.push && (!full || pop);
    assign drop    = bus.push && full && !pop;

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign drop_count   = drop_count_q;
    assign sending      = sending_q;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drop_count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read.
    // When full and popping, the write lands on the head slot; the pop still sees the old head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.push_nonce;
        end
    end

    // tx_start/tx_data are registered: they are set on the edge entering StStart, so the
    // strobe is high exactly for the cycle spent in StStart.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            byte_cnt_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            sending_q  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Waiting out tx_busy here covers an async_tx still finishing a byte
                    // abandoned by a reset, so no strobe is ever issued while it is busy.
                    if (!empty && !bus.tx_busy) begin
                        state_q   <= StLoad;
                        sending_q <= 1'b1;
                    end
                end
                StLoad: begin
                    sh_q       <= head;
                    byte_cnt_q <= '0;
                    tx_start_q <= 1'b1;
                    tx_data_q  <= first_byte(head);
                    state_q    <= StStart;
                end
                StStart: begin
                    state_q <= StAck;
                end
                StAck: begin
                    // async_tx raises busy this cycle; move the next byte into position.
                    sh_q    <= MSB_FIRST ? {sh_q[23:0], 8'h00} : {8'h00, sh_q[31:8]};
                    state_q <= StWait;
                end
                StWait: begin
                    if (!bus.tx_busy) begin
                        if (byte_cnt_q == 2'd3) begin
                            state_q   <= StIdle;
                            sending_q <= 1'b0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            tx_start_q <= 1'b1;
                            tx_data_q  <= first_byte(sh_q);
                            state_q    <= StStart;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    sending_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_golden_nonce_tx_queue.sv
`timescale 1ns/1ps
// tb_golden_nonce_tx_queue
//  Two DUTs (LSB-first and MSB-first) share clock and reset. Each has an async_tx busy model
//  (busy rises the edge after tx_start, holds BUSY_CYC cycles). Expected bytes are queued when a
//  nonce is pushed and compared when the DUT strobes tx_start.
module tb_golden_nonce_tx_queue;
    localparam int BUSY_CYC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    golden_nonce_tx_queue_if bus0 ();
    golden_nonce_tx_queue_if bus1 ();

    logic       empty0, full0, sending0, empty1, full1, sending1;
    logic [2:0] level0, level1;
    logic [7:0] drop0, drop1;

    golden_nonce_tx_queue #(.DEPTH_LOG2(2), .MSB_FIRST(1'b0)) dut0 (
        .clk        (clk),
        .reset_in   (rst_n),
        .bus        (bus0.slave),
        .empty      (empty0),
        .full       (full0),
        .level      (level0),
        .drop_count (drop0),
        .sending    (sending0)
    );

    golden_nonce_tx_queue #(.DEPTH_LOG2(2), .MSB_FIRST(1'b1)) dut1 (
        .clk        (clk),
        .reset_in   (rst_n),
        .bus        (bus1.slave),
        .empty      (empty1),
        .full       (full1),
        .level      (level1),
        .drop_count (drop1),
        .sending    (sending1)
    );

    int passed = 0;
    int total  = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    int starts0 = 0;
    int starts1 = 0;
    bit stuck0 = 1'b0;
    int cnt0 = 0;
    int cnt1 = 0;

    typedef struct {
        logic [31:0] nonce;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // async_tx busy models
    always @(posedge clk) begin
        if (stuck0) begin
            bus0.tx_busy <= 1'b1;
            cnt0 <= 0;
        end else if (bus0.tx_start) begin
            bus0.tx_busy <= 1'b1;
            cnt0 <= BUSY_CYC;
        end else if (cnt0 > 1) begin
            cnt0 <= cnt0 - 1;
        end else begin
            bus0.tx_busy <= 1'b0;
            cnt0 <= 0;
        end
    end

    always @(posedge clk) begin
        if (bus1.tx_start) begin
            bus1.tx_busy <= 1'b1;
            cnt1 <= BUSY_CYC;
        end else if (cnt1 > 1) begin
            cnt1 <= cnt1 - 1;
        end else begin
            bus1.tx_busy <= 1'b0;
            cnt1 <= 0;
        end
    end

    // Byte monitors / scoreboards
    always @(negedge clk) begin
        if (rst_n && bus0.tx_start) begin
            starts0++;
            check("no_start_while_busy0", bus0.tx_busy, 0);
            if (exp0.size() == 0) begin
                total++;
                $display("FAIL unexpected_tx_start0: got data %h, required no strobe", bus0.tx_data);
            end else begin
                check("tx_byte0", bus0.tx_data, exp0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.tx_start) begin
            starts1++;
            check("no_start_while_busy1", bus1.tx_busy, 0);
            if (exp1.size() == 0) begin
                total++;
                $display("FAIL unexpected_tx_start1: got data %h, required no strobe", bus1.tx_data);
            end else begin
                check("tx_byte1", bus1.tx_data, exp1.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus0.push = 1'b0;
        bus1.push = 1'b0;
        exp0.delete();
        exp1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic enq_lsb(input logic [31:0] n);
        exp0.push_back(n[7:0]);
        exp0.push_back(n[15:8]);
        exp0.push_back(n[23:16]);
        exp0.push_back(n[31:24]);
    endtask

    // Called at a negedge; leaves push asserted and returns at the next negedge.
    task automatic drive0(input logic [31:0] n, input bit model);
        bus0.push = 1'b1;
        bus0.push_nonce = n;
        if (model) enq_lsb(n);
        @(negedge clk);
    endtask

    task automatic wait_idle0(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp0.size() == 0 && !sending0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;
        bus0.push = 1'b0;
        bus0.push_nonce = '0;
        bus1.push = 1'b0;
        bus1.push_nonce = '0;

        tbl[0] = '{32'h0102_0304, 8'h04, 8'h03, 8'h02, 8'h01};
        tbl[1] = '{32'h8000_0001, 8'h01, 8'h00, 8'h00, 8'h80};
        tbl[2] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00};

        // Test 1: reset state, latency, LSB-first order
        do_reset();
        check("rst_level", level0, 0);
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_drop", drop0, 0);
        check("rst_sending", sending0, 0);
        check("rst_tx_start", bus0.tx_start, 0);
        check("rst_tx_data", bus0.tx_data, 0);
        base = starts0;
        drive0(32'h1234_5678, 1'b1);
        bus0.push = 1'b0;
        check("t1_level_after_push", level0, 1);
        check("t1_empty_after_push", empty0, 0);
        check("t1_idle_at_t", sending0, 0);
        @(negedge clk);
        check("t1_load_at_t1", sending0, 1);
        check("t1_no_start_at_t1", bus0.tx_start, 0);
        @(negedge clk);
        check("t1_start_at_t2", bus0.tx_start, 1);
        check("t1_level_after_pop", level0, 0);
        wait_idle0("t1_done");
        check("t1_empty_end", empty0, 1);
        check("t1_four_strobes", starts0 - base, 4);

        // Test 2: MSB-first order on second DUT
        base = starts1;
        @(negedge clk);
        bus1.push = 1'b1;
        bus1.push_nonce = 32'hDEAD_BEEF;
        exp1.push_back(8'hDE);
        exp1.push_back(8'hAD);
        exp1.push_back(8'hBE);
        exp1.push_back(8'hEF);
        @(negedge clk);
        bus1.push = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (exp1.size() == 0 && !sending1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t2_done", seen, 1);
        check("t2_four_strobes", starts1 - base, 4);
        check("t2_empty_end", empty1, 1);

        // Test 3: six back-to-back pushes, A5 dropped
        do_reset();
        for (int i = 0; i < 5; i++) drive0(32'hA0A0_0000 + i, 1'b1);
        check("t3_full_after_a4", full0, 1);
        check("t3_level_after_a4", level0, 4);
        drive0(32'hA0A0_0005, 1'b0);
        bus0.push = 1'b0;
        check("t3_level_after_a5", level0, 4);
        check("t3_drop_after_a5", drop0, 1);
        wait_idle0("t3_done");
        check("t3_full_end", full0, 0);
        check("t3_empty_end", empty0, 1);
        check("t3_drop_end", drop0, 1);

        // Test 4: tx_busy stuck high, 300 pushes, saturation
        stuck0 = 1'b1;
        do_reset();
        base = starts0;
        for (int i = 0; i < 300; i++) begin
            drive0(32'hC0DE_0000 + i, i < 4);
            if (i == 3) check("t4_full_after_4", full0, 1);
            if (i == 257) check("t4_drop_254", drop0, 254);
        end
        bus0.push = 1'b0;
        check("t4_level", level0, 4);
        check("t4_drop_sat", drop0, 255);
        check("t4_no_start_stuck", starts0 - base, 0);
        stuck0 = 1'b0;
        wait_idle0("t4_drain");
        check("t4_drop_held", drop0, 255);

        // Test 6: push while full, same cycle as LOAD pop
        stuck0 = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) drive0(32'hB0B0_0000 + i, 1'b1);
        bus0.push = 1'b0;
        check("t6_full_before", full0, 1);
        stuck0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sending0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_load_seen", seen, 1);
        check("t6_level_in_load", level0, 4);
        drive0(32'hB0B0_0004, 1'b1);
        bus0.push = 1'b0;
        check("t6_level_kept", level0, 4);
        check("t6_drop_unchanged", drop0, 0);
        check("t6_full_kept", full0, 1);
        wait_idle0("t6_done");
        check("t6_empty_end", empty0, 1);

        // Test 5: reset mid-byte 2 with two nonces queued
        do_reset();
        base = starts0;
        drive0(32'h5555_0001, 1'b1);
        drive0(32'h5555_0002, 1'b1);
        drive0(32'h5555_0003, 1'b1);
        bus0.push = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (starts0 - base >= 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_byte2_seen", seen, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tx_start", bus0.tx_start, 0);
        check("t5_tx_data", bus0.tx_data, 0);
        check("t5_level", level0, 0);
        check("t5_empty", empty0, 1);
        check("t5_full", full0, 0);
        check("t5_drop", drop0, 0);
        check("t5_sending", sending0, 0);
        exp0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t5_no_start_after_reset", starts0 - base, 2);

        // Table vectors: one nonce at a time through the full path
        for (int v = 0; v < 4; v++) begin
            base = starts0;
            exp0.push_back(tbl[v].b0);
            exp0.push_back(tbl[v].b1);
            exp0.push_back(tbl[v].b2);
            exp0.push_back(tbl[v].b3);
            drive0(tbl[v].nonce, 1'b0);
            bus0.push = 1'b0;
            wait_idle0("tbl_done");
            check("tbl_strobes", starts0 - base, 4);
            check("tbl_empty", empty0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
